joystick_position_unit: RTL and testbench

- Conditions the four raw joystick buttons and produces the clamped joystick X/Y position for the racing game.
- Produces the registered hpaddle/vpaddle beam-compare flags consumed by the top level's IN_FLAGS read register.
- Replaces the free-running 100 Hz position counter with synchronised, debounced inputs, an immediate first step on press, and rate-limited auto-repeat.
- Sits between the board button pins and the CPU flag/read mux. Runs on the 25 MHz pixel clock.

---
 rtl/joystick_position_unit.sv | 148 ++++++++++++++
 tb/tb_joystick_position_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/joystick_position_unit.sv
// Joystick position unit: conditions the four raw direction buttons
// (2-flop synchroniser + per-button debounce), steps a clamped X/Y
// position with an immediate first step and rate-limited auto-repeat,
// and registers the paddle beam-compare flags against the current scanline.
module joystick_position_unit #(
  parameter logic [9:0]  X_INIT          = 10'd320,
  parameter logic [9:0]  X_MAX           = 10'd624,
  parameter logic [9:0]  Y_INIT          = 10'd16,
  parameter logic [9:0]  Y_MIN           = 10'd16,
  parameter logic [9:0]  Y_MAX           = 10'd128,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned STEP_DIV        = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic [9:0] vpos,
  output logic [9:0] joy_x,
  output logic [9:0] joy_y,
  output logic       hpaddle,
  output logic       vpaddle,
  output logic       moving
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned SW = $clog2(STEP_DIV) + 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] DIV_LAST = SW'(STEP_DIV - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] REPEAT = 1'b1;

  // Button bit order: 0=left, 1=right, 2=up, 3=down.
  logic [3:0]    raw;
  logic [3:0]    sync_a;
  logic [3:0]    sync_b;
  logic [3:0]    deb;
  logic [DW-1:0] deb_cnt [4];

  logic [0:0]    state;
  logic [0:0]    state_next;
  logic [SW-1:0] div;
  logic [SW-1:0] div_next;
  logic          step;
  logic [9:0]    step_x;
  logic [9:0]    step_y;

  assign raw    = {down, up, right, left};
  assign moving = (state == REPEAT);

  // Two-flop synchroniser for the asynchronous button pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Per-button debounce: level only follows after DEBOUNCE_CYCLES stable clocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb <= '0;
      for (int unsigned i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync_b[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync_b[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Candidate position for a step: fixed priority, a blocked winner still wins.
  always_comb begin
    step_x = joy_x;
    step_y = joy_y;
    if (deb[0]) begin
      if (joy_x != '0) step_x = joy_x - 10'd1;
    end else if (deb[1]) begin
      if (joy_x != X_MAX) step_x = joy_x + 10'd1;
    end else if (deb[2]) begin
      if (joy_y != Y_MIN) step_y = joy_y - 10'd1;
    end else if (deb[3]) begin
      if (joy_y != Y_MAX) step_y = joy_y + 10'd1;
    end
  end

  // Repeat FSM: immediate step on press, then one step per divider wrap;
  // release takes precedence over a coincident divider tick.
  always_comb begin
    state_next = state;
    div_next   = div;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (|deb) begin
          step       = 1'b1;
          div_next   = '0;
          state_next = REPEAT;
        end
      end
      default: begin
        if (~|deb) begin
          div_next   = '0;
          state_next = IDLE;
        end else if (div == DIV_LAST) begin
          step     = 1'b1;
          div_next = '0;
        end else begin
          div_next = div + SW'(1);
        end
      end
    endcase
  end

  // State, divider, position and paddle-flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      div     <= '0;
      joy_x   <= X_INIT;
      joy_y   <= Y_INIT;
      hpaddle <= 1'b0;
      vpaddle <= 1'b0;
    end else begin
      state   <= state_next;
      div     <= div_next;
      hpaddle <= (joy_x == vpos);
      vpaddle <= (joy_y == vpos);
      if (step) begin
        joy_x <= step_x;
        joy_y <= step_y;
      end
    end
  end

endmodule

// File: tb/tb_joystick_position_unit.sv
// Directed bench for joystick_position_unit with DEBOUNCE_CYCLES=4, STEP_DIV=8.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after an edge.
// Counting rising edges from the one right after a button is driven, the
// first step is visible after edge 7 and later steps after edges 15, 23, ...
module tb_joystick_position_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       left, right, up, down;
  logic [9:0] vpos;
  logic [9:0] joy_x, joy_y;
  logic       hpaddle, vpaddle, moving;

  int tests    = 0;
  int failures = 0;

  joystick_position_unit #(
    .X_INIT(10'd320), .X_MAX(10'd624), .Y_INIT(10'd16), .Y_MIN(10'd16),
    .Y_MAX(10'd128), .DEBOUNCE_CYCLES(4), .STEP_DIV(8)
  ) dut (
    .clk(clk), .reset(reset), .left(left), .right(right), .up(up), .down(down),
    .vpos(vpos), .joy_x(joy_x), .joy_y(joy_y), .hpaddle(hpaddle),
    .vpaddle(vpaddle), .moving(moving)
  );

  always #5 clk = ~clk;

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0;
    reset = 1'b0;
    clocks(3);
    reset = 1'b1;
  endtask

  task automatic buttons(input logic l, input logic r, input logic u, input logic d);
    left = l; right = r; up = u; down = d;
  endtask

  initial begin
    vpos = 10'd0;
    buttons(1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();

    // 1: reset mid-run while moving
    buttons(1'b0, 1'b1, 1'b0, 1'b0);
    clocks(20);
    check("pre_reset_x", 32'(joy_x), 32'd322);
    #2 reset = 1'b0;
    #1;
    check("rst_x_async", 32'(joy_x), 32'd320);
    check("rst_mov_async", 32'(moving), 32'd0);
    clocks(3);
    check("rst_x_held", 32'(joy_x), 32'd320);
    check("rst_y_held", 32'(joy_y), 32'd16);
    check("rst_hp_held", 32'(hpaddle), 32'd0);
    check("rst_vp_held", 32'(vpaddle), 32'd0);
    check("rst_mov_held", 32'(moving), 32'd0);
    buttons(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    clocks(2);
    check("post_rst_x", 32'(joy_x), 32'd320);
    check("post_rst_y", 32'(joy_y), 32'd16);
    check("post_rst_mov", 32'(moving), 32'd0);

    // 2: 3-clock glitch rejected, then held right steps and repeats
    do_reset();
    buttons(1'b0, 1'b1, 1'b0, 1'b0);
    clocks(3);
    buttons(1'b0, 1'b0, 1'b0, 1'b0);
    clocks(12);
    check("glitch_x", 32'(joy_x), 32'd320);
    check("glitch_mov", 32'(moving), 32'd0);
    buttons(1'b0, 1'b1, 1'b0, 1'b0);
    clocks(6);
    check("hold_x_e6", 32'(joy_x), 32'd320);
    check("hold_mov_e6", 32'(moving), 32'd0);
    clocks(1);
    check("hold_x_e7", 32'(joy_x), 32'd321);
    check("hold_mov_e7", 32'(moving), 32'd1);
    clocks(7);
    check("hold_x_e14", 32'(joy_x), 32'd321);
    clocks(1);
    check("hold_x_e15", 32'(joy_x), 32'd322);
    clocks(8);
    check("hold_x_e23", 32'(joy_x), 32'd323);

    // 3: clamps
    clocks(2400);
    check("right_623", 32'(joy_x), 32'd623);
    clocks(8);
    check("right_624", 32'(joy_x), 32'd624);
    clocks(40);
    check("right_hold_624", 32'(joy_x), 32'd624);

    do_reset();
    buttons(1'b1, 1'b0, 1'b0, 1'b0);
    clocks(2551);
    check("left_1", 32'(joy_x), 32'd1);
    clocks(8);
    check("left_0", 32'(joy_x), 32'd0);
    clocks(40);
    check("left_hold_0", 32'(joy_x), 32'd0);

    do_reset();
    buttons(1'b0, 1'b0, 1'b1, 1'b0);
    clocks(30);
    check("up_y_16", 32'(joy_y), 32'd16);
    check("up_x", 32'(joy_x), 32'd320);
    check("up_mov", 32'(moving), 32'd1);

    do_reset();
    buttons(1'b0, 1'b0, 1'b0, 1'b1);
    clocks(887);
    check("down_127", 32'(joy_y), 32'd127);
    clocks(8);
    check("down_128", 32'(joy_y), 32'd128);
    clocks(40);
    check("down_hold_128", 32'(joy_y), 32'd128);

    // 4: left+right+up together -> left wins
    do_reset();
    buttons(1'b1, 1'b1, 1'b1, 1'b0);
    clocks(7);
    check("prio_x_319", 32'(joy_x), 32'd319);
    clocks(8);
    check("prio_x_318", 32'(joy_x), 32'd318);
    check("prio_y_16", 32'(joy_y), 32'd16);

    // 5: release coinciding with divider tick, then immediate re-press step
    do_reset();
    buttons(1'b0, 1'b1, 1'b0, 1'b0);
    clocks(16);
    check("rel_x_before", 32'(joy_x), 32'd322);
    buttons(1'b0, 1'b0, 1'b0, 1'b0);
    clocks(6);
    check("rel_x_e22", 32'(joy_x), 32'd322);
    check("rel_mov_e22", 32'(moving), 32'd1);
    clocks(1);
    check("rel_x_tick", 32'(joy_x), 32'd322);
    check("rel_mov_tick", 32'(moving), 32'd0);
    buttons(1'b0, 1'b1, 1'b0, 1'b0);
    clocks(6);
    check("repress_x_e6", 32'(joy_x), 32'd322);
    clocks(1);
    check("repress_x_e7", 32'(joy_x), 32'd323);
    check("repress_mov", 32'(moving), 32'd1);

    // 6: paddle flags, one clock latency
    do_reset();
    vpos = 10'd320;
    #1;
    check("hp_no_edge", 32'(hpaddle), 32'd0);
    clocks(1);
    check("hp_320", 32'(hpaddle), 32'd1);
    check("vp_320", 32'(vpaddle), 32'd0);
    vpos = 10'd16;
    clocks(1);
    check("hp_16", 32'(hpaddle), 32'd0);
    check("vp_16", 32'(vpaddle), 32'd1);
    vpos = 10'd5;
    clocks(1);
    check("hp_5", 32'(hpaddle), 32'd0);
    check("vp_5", 32'(vpaddle), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
